// File: rtl/branch_target_unit.sv
// Branch target calculator with a valid/ready result stage, plus an optional direct-mapped BTB.
// The BTB is built only when BRANCH_TARGET_BTB_EN is defined; otherwise the prediction outputs read 0.
module branch_target_unit #(
  parameter int XLEN         = 32,
  parameter int BTB_DEPTH    = 16,
  parameter int OFFSET_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            calc_valid,
  output logic            calc_ready,
  input  logic [XLEN-1:0] calc_pc,
  input  logic [XLEN-1:0] calc_offset,
  output logic            tgt_valid,
  input  logic            tgt_ready,
  output logic [XLEN-1:0] tgt_addr,
  output logic            tgt_misalign,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  logic [XLEN-1:0] shifted_offset;
  logic [XLEN-1:0] target_sum;
  logic            calc_accept;

  assign shifted_offset = calc_offset << OFFSET_SHIFT;
  assign target_sum     = calc_pc + shifted_offset;
  assign calc_ready     = !tgt_valid || tgt_ready;
  assign calc_accept    = calc_valid && calc_ready;

  // Result register: loads on accept, empties on drain, otherwise holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_valid    <= 1'b0;
      tgt_addr     <= '0;
      tgt_misalign <= 1'b0;
    end else if (calc_accept) begin
      tgt_valid    <= 1'b1;
      tgt_addr     <= target_sum;
      tgt_misalign <= (target_sum[1:0] != 2'b00);
    end else if (tgt_ready) begin
      tgt_valid    <= 1'b0;
    end
  end

`ifdef BRANCH_TARGET_BTB_EN

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];
  logic [1:0]           btb_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_alloc;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[XLEN-1:IDX_W+2];
  assign lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit   = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  assign up_alloc = upd_valid && !up_hit && upd_taken;

  // Lookup samples the arrays before this edge's update lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_hit    <= lk_hit;
      pred_taken  <= lk_hit && btb_ctr[lk_idx][1];
      pred_target <= lk_hit ? btb_target[lk_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else if (up_alloc) begin
      btb_valid[up_idx] <= 1'b1;
    end
  end

  // Entry payload carries no reset; the valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (upd_valid && up_hit) begin
      if (upd_taken) begin
        btb_target[up_idx] <= upd_target;
        if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
      end else if (btb_ctr[up_idx] != 2'b00) begin
        btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
      end
    end else if (up_alloc) begin
      btb_tag[up_idx]    <= up_tag;
      btb_target[up_idx] <= upd_target;
      btb_ctr[up_idx]    <= 2'b10;
    end
  end

  logic unused_pc_low;
  assign unused_pc_low = ^{lookup_pc[1:0], upd_pc[1:0]};

`else

  assign pred_hit    = 1'b0;
  assign pred_taken  = 1'b0;
  assign pred_target = '0;

  logic unused_btb_inputs;
  assign unused_btb_inputs = ^{lookup_pc, upd_valid, upd_taken, upd_pc, upd_target};

`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: calculation path, backpressure, BTB behaviour and reset.
// BTB expectations follow whether BRANCH_TARGET_BTB_EN is defined for the build.
module tb_branch_target_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        calc_valid, calc_ready;
  logic [31:0] calc_pc, calc_offset;
  logic        tgt_valid, tgt_ready, tgt_misalign;
  logic [31:0] tgt_addr;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;

  int compared   = 0;
  int mismatched = 0;

`ifdef BRANCH_TARGET_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  branch_target_unit #(.XLEN(32), .BTB_DEPTH(16), .OFFSET_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .calc_valid(calc_valid), .calc_ready(calc_ready),
    .calc_pc(calc_pc), .calc_offset(calc_offset),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_addr(tgt_addr), .tgt_misalign(tgt_misalign),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken),
    .upd_pc(upd_pc), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic [31:0] pc, input logic [31:0] off, input logic tr);
    calc_valid  = cv;
    calc_pc     = pc;
    calc_offset = off;
    tgt_ready   = tr;
  endtask

  task automatic applyUpdate(input logic uv, input logic ut, input logic [31:0] pc, input logic [31:0] tg);
    upd_valid  = uv;
    upd_taken  = ut;
    upd_pc     = pc;
    upd_target = tg;
  endtask

  function automatic logic [31:0] btbExp(input logic [31:0] v);
    return BTB_ON ? v : 32'h0;
  endfunction

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    lookup_pc = 32'h0;
    tick();
    tick();
    checkOutput("reset_tgt_valid",   {31'b0, tgt_valid},    32'h0);
    checkOutput("reset_tgt_addr",    tgt_addr,              32'h0);
    checkOutput("reset_misalign",    {31'b0, tgt_misalign}, 32'h0);
    checkOutput("reset_pred_hit",    {31'b0, pred_hit},     32'h0);
    checkOutput("reset_pred_taken",  {31'b0, pred_taken},   32'h0);
    checkOutput("reset_pred_target", pred_target,           32'h0);
    checkOutput("reset_calc_ready",  {31'b0, calc_ready},   32'h1);
    rst_n = 1'b1;

    // Negative offset, wrap-around and misalignment
    applyStimulus(1'b1, 32'h0000_1000, 32'hFFFF_FFF8, 1'b1);
    tick();
    checkOutput("neg_off_valid", {31'b0, tgt_valid},    32'h1);
    checkOutput("neg_off_addr",  tgt_addr,              32'h0000_0FF8);
    checkOutput("neg_off_mis",   {31'b0, tgt_misalign}, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1);
    tick();
    checkOutput("wrap_addr", tgt_addr,              32'h0000_0004);
    checkOutput("wrap_mis",  {31'b0, tgt_misalign}, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0000_0002, 1'b1);
    tick();
    checkOutput("misalign_addr", tgt_addr,              32'hFFFF_FFFE);
    checkOutput("misalign_flag", {31'b0, tgt_misalign}, 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("drain_valid", {31'b0, tgt_valid}, 32'h0);

    // Backpressure for three cycles, then back-to-back drain
    applyStimulus(1'b1, 32'h0000_2000, 32'h0000_0010, 1'b0);
    tick();
    checkOutput("bp_first_addr", tgt_addr, 32'h0000_2010);
    applyStimulus(1'b1, 32'h0000_3000, 32'h0000_0010, 1'b0);
    #1;
    checkOutput("bp_ready_low", {31'b0, calc_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_valid", {31'b0, tgt_valid},  32'h1);
      checkOutput("bp_hold_addr",  tgt_addr,            32'h0000_2010);
      checkOutput("bp_hold_ready", {31'b0, calc_ready}, 32'h0);
    end
    tgt_ready = 1'b1;
    #1;
    checkOutput("bp_ready_high", {31'b0, calc_ready}, 32'h1);
    tick();
    checkOutput("b2b_addr0", tgt_addr, 32'h0000_3010);
    applyStimulus(1'b1, 32'h0000_4000, 32'h0000_0010, 1'b1);
    tick();
    checkOutput("b2b_addr1",  tgt_addr,             32'h0000_4010);
    checkOutput("b2b_valid1", {31'b0, tgt_valid},   32'h1);
    applyStimulus(1'b1, 32'h0000_5000, 32'h0000_0010, 1'b1);
    tick();
    checkOutput("b2b_addr2", tgt_addr, 32'h0000_5010);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("b2b_drained", {31'b0, tgt_valid}, 32'h0);

    // BTB allocate at 0x40, then two not-taken updates
    lookup_pc = 32'h0000_0040;
    applyUpdate(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0080);
    tick();
    checkOutput("alloc_same_cycle_hit", {31'b0, pred_hit}, 32'h0);
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("alloc_hit",    {31'b0, pred_hit},   btbExp(32'h1));
    checkOutput("alloc_taken",  {31'b0, pred_taken}, btbExp(32'h1));
    checkOutput("alloc_target", pred_target,         btbExp(32'h80));
    applyUpdate(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0999);
    tick();
    checkOutput("nt1_taken_old", {31'b0, pred_taken}, btbExp(32'h1));
    tick();
    checkOutput("nt2_taken", {31'b0, pred_taken}, 32'h0);
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("nt_hit",    {31'b0, pred_hit},   btbExp(32'h1));
    checkOutput("nt_taken",  {31'b0, pred_taken}, 32'h0);
    checkOutput("nt_target", pred_target,         btbExp(32'h80));

    // Not-taken miss leaves the BTB alone; an unallocated index misses
    applyUpdate(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300);
    tick();
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    lookup_pc = 32'h0000_0200;
    tick();
    checkOutput("nt_miss_no_alloc", {31'b0, pred_hit}, 32'h0);
    lookup_pc = 32'h0000_0040;
    tick();
    checkOutput("nt_miss_kept_old", {31'b0, pred_hit}, btbExp(32'h1));
    lookup_pc = 32'h0000_0044;
    tick();
    checkOutput("empty_index_miss", {31'b0, pred_hit}, 32'h0);

    // Same-cycle lookup and replacing taken update at 0x100
    lookup_pc = 32'h0000_0100;
    applyUpdate(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0180);
    tick();
    checkOutput("rbw_hit", {31'b0, pred_hit}, 32'h0);
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rbw_next_hit",    {31'b0, pred_hit},   btbExp(32'h1));
    checkOutput("rbw_next_target", pred_target,         btbExp(32'h180));
    lookup_pc = 32'h0000_0040;
    tick();
    checkOutput("replaced_old_miss", {31'b0, pred_hit}, 32'h0);

    // Counter saturates at 11: two taken then one not-taken keeps it predicting taken
    lookup_pc = 32'h0000_0100;
    applyUpdate(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0180);
    tick();
    tick();
    applyUpdate(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0180);
    tick();
    applyUpdate(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("sat_taken", {31'b0, pred_taken}, btbExp(32'h1));

    // Reset mid-operation with a held result and a populated BTB
    applyStimulus(1'b1, 32'h0000_1000, 32'h0000_0004, 1'b0);
    tick();
    checkOutput("pre_reset_valid", {31'b0, tgt_valid}, 32'h1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checkOutput("mid_reset_valid", {31'b0, tgt_valid}, 32'h0);
    checkOutput("mid_reset_addr",  tgt_addr,           32'h0);
    checkOutput("mid_reset_hit",   {31'b0, pred_hit},  32'h0);
    rst_n = 1'b1;
    checkOutput("post_reset_ready", {31'b0, calc_ready}, 32'h1);
    lookup_pc = 32'h0000_0100;
    tick();
    checkOutput("post_reset_lookup", {31'b0, pred_hit}, 32'h0);
    checkOutput("post_reset_target", pred_target,       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and data width in bits.
REQ-002 SHALL have parameter BTB_DEPTH, default 16: number of BTB entries; power of two, at least 2.
REQ-003 SHALL have parameter OFFSET_SHIFT, default 0: left shift applied to calc_offset before the add.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port calc_valid, input, 1 bit: a target request is present.
REQ-007 SHALL have port calc_ready, output, 1 bit: the unit can accept a request.
REQ-008 SHALL have ports calc_pc and calc_offset, input, XLEN bits each: branch PC and sign-extended offset.
REQ-009 SHALL have port tgt_valid, output, 1 bit: tgt_addr holds a result.
REQ-010 SHALL have port tgt_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port tgt_addr, output, XLEN bits: the computed target.
REQ-012 SHALL have port tgt_misalign, output, 1 bit: tgt_addr[1:0] is not 2'b00.
REQ-013 SHALL have port lookup_pc, input, XLEN bits: fetch PC, sampled every cycle.
REQ-014 SHALL have ports pred_hit, pred_taken, output, 1 bit each, and port pred_target, output, XLEN bits: the BTB prediction.
REQ-015 SHALL have ports upd_valid and upd_taken, input, 1 bit each, and ports upd_pc and upd_target, input, XLEN bits each: branch resolution update.

Function
REQ-016 SHALL compute tgt_addr = calc_pc + (calc_offset << OFFSET_SHIFT), truncated modulo 2^XLEN, so wrap-around is silent.
REQ-017 SHALL drive calc_ready = !tgt_valid || tgt_ready, combinationally.
REQ-018 SHALL accept a request when calc_valid && calc_ready, with tgt_valid=1 and the result registered on the next edge (latency 1 cycle).
REQ-019 SHALL hold tgt_valid, tgt_addr and tgt_misalign stable while tgt_valid && !tgt_ready.
REQ-020 SHALL clear tgt_valid when tgt_ready && !(calc_valid && calc_ready); a simultaneous accept and drain gives full throughput, one result per cycle.
REQ-021 SHALL index the BTB with pc[log2(BTB_DEPTH)+1:2] and tag it with the remaining upper PC bits; each entry holds valid, tag, target and a 2-bit counter.
REQ-022 SHALL register the lookup with 1-cycle latency: pred_hit = entry valid && tag match; pred_taken = pred_hit && ctr[1]; pred_target = target on a hit, else 0.
REQ-023 SHALL, on upd_valid with a hit, increment ctr on taken (saturating at 11) or decrement it on not-taken (saturating at 00), and write upd_target on taken.
REQ-024 SHALL, on upd_valid with a miss and upd_taken=1, allocate or replace the entry with valid=1, the new tag, upd_target and ctr=2'b10.
REQ-025 SHALL make no BTB change on upd_valid with a miss and upd_taken=0.
REQ-026 SHALL give read-before-write when a lookup and an update hit the same index in the same cycle: the lookup returns the old contents.
REQ-027 SHALL operate the calculation path and the BTB path fully independently; neither stalls the other.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, clear tgt_valid, tgt_addr, tgt_misalign, pred_hit, pred_taken and pred_target to 0, and clear all BTB valid bits.
REQ-029 SHALL discard any in-flight or held result on reset mid-operation; calc_ready reads 1 in the first cycle after reset.
REQ-030 SHALL leave BTB targets, tags and counters uninitialised, made unobservable by the cleared valid bits.

Configuration
REQ-031 SHALL include the BTB storage, lookup and update logic (REQ-021..026) when macro BRANCH_TARGET_BTB_EN is defined.
REQ-032 SHALL, without BRANCH_TARGET_BTB_EN, tie pred_hit, pred_taken and pred_target to 0, ignore the update and lookup inputs, and build no BTB storage; the calculation path is unchanged.

Verification
REQ-033 SHALL cover: calc_pc=0x00001000, calc_offset=0xFFFFFFF8, OFFSET_SHIFT=0 -> next cycle tgt_valid=1, tgt_addr=0x00000FF8, tgt_misalign=0.
REQ-034 SHALL cover: calc_pc=0xFFFFFFFC, calc_offset=0x00000008 -> tgt_addr=0x00000004 (wrap); calc_offset=0x2 -> tgt_misalign=1.
REQ-035 SHALL cover: tgt_ready held 0 for 3 cycles with calc_valid=1 -> calc_ready=0 and tgt_addr stable; then tgt_ready=1 -> back-to-back results, one per cycle.
REQ-036 SHALL cover: update pc=0x40, taken, target 0x80, then lookup 0x40 -> pred_hit=1, pred_taken=1, pred_target=0x80; two not-taken updates -> pred_taken=0 (ctr=00).
REQ-037 SHALL cover: same-cycle lookup and taken-miss update to pc=0x100 -> pred_hit=0 that cycle; lookup on the following cycle -> pred_hit=1.
REQ-038 SHALL cover: rst_n=0 for one edge while tgt_valid=1 and the BTB is populated -> tgt_valid=0, and a lookup of any previously hit PC returns pred_hit=0.
